serial_to_parallel_aligner: RTL
===============================

Name: serial_to_parallel_aligner

Overview:
Receive-side front end for one lane. It accepts the serial bitstream produced from a phy_TX lane byte, MSB first. It finds byte alignment on the COM symbol and locks after a fixed number of consecutive COMs. Once locked, it delivers 8-bit data bytes with a valid flag to the RX lane un-striping logic. Idle COM symbols are stripped; they are not forwarded as data.

Parameters:
COM_SYMBOL, 8'hBC, alignment/idle symbol.
LOCK_COUNT, 4, consecutive byte-aligned COMs required to enter ACTIVE (legal range 2..15).

Ports:
clk_32f  input  1  bit clock; 8 cycles per byte.
reset  input  1  asynchronous, active-low reset.
serial_in  input  1  serial data, MSB of each byte first, sampled on rising edge of clk_32f.
data_out  output  8  received data byte, registered.
valid_out  output  1  data_out holds a valid non-COM byte, registered.
active  output  1  lane is locked (state == ACTIVE), registered.

Behaviour:
- Reset (reset low, asynchronous):
  - shift_reg = 8'h00, bit_cnt = 0, com_cnt = 0, state = SEARCH.
  - data_out = 8'h00, valid_out = 0, active = 0.
- Shift register, every rising edge: shift_reg <= {shift_reg[6:0], serial_in}.
- bit_cnt: 3-bit, wraps 7 -> 0.
- Boundary cycle: bit_cnt == 7 in state ALIGN or ACTIVE. In that cycle shift_reg holds one complete aligned byte.
- SEARCH:
  - bit_cnt is don't-care.
  - The comparison is evaluated every cycle on the registered value of shift_reg.
  - When shift_reg == COM_SYMBOL: bit_cnt <= 0, com_cnt <= 1, state <= ALIGN.
  - The next boundary occurs exactly 8 cycles after the detection cycle.
- ALIGN:
  - bit_cnt increments every cycle.
  - The COM check is evaluated only at boundaries.
  - Boundary with shift_reg == COM_SYMBOL: com_cnt <= com_cnt + 1. When com_cnt + 1 == LOCK_COUNT, state <= ACTIVE and com_cnt <= 0.
  - Boundary with shift_reg != COM_SYMBOL: state <= SEARCH, com_cnt <= 0. The byte is discarded; no output is produced.
  - A false COM match inside arbitrary data is resolved by this rule; the block makes no other protection against it.
- ACTIVE:
  - active = 1, one edge after the boundary at which lock was reached.
  - The lock-completing COM is never output; the first possible data byte is the next boundary.
  - Boundary with shift_reg != COM_SYMBOL: data_out <= shift_reg, valid_out <= 1.
  - Boundary with shift_reg == COM_SYMBOL: valid_out <= 0, data_out holds its previous value.
  - Between boundaries, data_out and valid_out are held, so each byte or idle window lasts exactly 8 cycles.
  - ACTIVE is left only through reset; there is no loss-of-lock detection in this block.
- Latency: data_out/valid_out update one clk_32f edge after the edge that samples the last bit of the byte.
- Outputs in SEARCH and ALIGN: valid_out = 0 and data_out holds its last value. After reset that value is 8'h00.
- Reset asserted mid-byte in any state: all registers clear immediately. Re-lock requires a fresh SEARCH plus LOCK_COUNT COMs.
- Reset released on a cycle: the first sample is taken on the next rising edge.

Test Plan:
- Reset: hold reset low 5 cycles with random serial_in -> data_out = 8'h00, valid_out = 0, active = 0 throughout.
- Lock:
  - Stimulus: prefix 3'b101, then 4 x 8'hBC MSB first.
  - Expected: active = 1 one edge after the last bit of the 4th COM is sampled; valid_out stays 0.
  - Expected: no earlier active, including during the prefix.
- Data after lock:
  - Stimulus: lock as above, then 8'hA5, 8'h3C.
  - Expected: data_out = 8'hA5 with valid_out = 1 for 8 cycles, then data_out = 8'h3C with valid_out = 1 for 8 cycles.
- Failed alignment:
  - Stimulus: 2 x 8'hBC, then 8'h55.
  - Expected: state returns to SEARCH and active stays 0.
  - Follow-up: 4 x 8'hBC -> active = 1.
- Idle stripping:
  - Stimulus: in ACTIVE, send 8'h12, 8'hBC, 8'h34.
  - Expected: 8'h12 valid for 8 cycles.
  - Expected: valid_out = 0 for the next 8 cycles with data_out held at 8'h12.
  - Expected: then 8'h34 valid.
- Mid-operation reset:
  - Stimulus: in ACTIVE, pulse reset low at bit 3 of a data byte.
  - Expected: outputs = 0 immediately.
  - Expected: after release, data bytes without COMs never set active; 4 COMs re-lock.

Source files
------------

// File: rtl/serial_to_parallel_aligner.sv
// Single-lane RX front end: shifts in an MSB-first bitstream, aligns to COM
// symbols, locks after LOCK_COUNT aligned COMs, then emits non-COM bytes.
module serial_to_parallel_aligner #(
   parameter logic [7:0] COM_SYMBOL = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      SEARCH,
      ALIGN,
      ACTIVE
   } state_t;

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

   state_t     state;
   logic [7:0] shift_reg;
   logic [2:0] bit_cnt;
   logic [3:0] com_cnt;
   logic       boundary;
   logic       is_com;

   assign boundary = (bit_cnt == 3'd7) && (state != SEARCH);
   assign is_com   = (shift_reg == COM_SYMBOL);

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state     <= SEARCH;
         shift_reg <= '0;
         bit_cnt   <= '0;
         com_cnt   <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         shift_reg <= {shift_reg[6:0], serial_in};
         bit_cnt   <= bit_cnt + 3'd1;
         case (state)
            SEARCH: begin
               // Detection cycle restarts the bit counter so the next
               // boundary lands exactly 8 cycles later.
               if (is_com) begin
                  bit_cnt <= '0;
                  com_cnt <= 4'd1;
                  state   <= ALIGN;
               end
            end
            ALIGN: begin
               if (boundary) begin
                  if (is_com) begin
                     if (com_cnt + 4'd1 == LOCK_CNT) begin
                        com_cnt <= '0;
                        state   <= ACTIVE;
                        active  <= 1'b1;
                     end else begin
                        com_cnt <= com_cnt + 4'd1;
                     end
                  end else begin
                     com_cnt <= '0;
                     state   <= SEARCH;
                  end
               end
            end
            ACTIVE: begin
               // COMs in the locked stream are idles: drop valid, hold data.
               if (boundary) begin
                  if (is_com) begin
                     valid_out <= 1'b0;
                  end else begin
                     data_out  <= shift_reg;
                     valid_out <= 1'b1;
                  end
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

endmodule
